// File: rtl/hex_display_n_if.sv
// Bundles the value/strobe/blink inputs and the segment/latched-value outputs of hex_display_n.
interface hex_display_n_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blink_en;
  logic [7*DIGITS-1:0]   seg;
  logic [4*DIGITS-1:0]   shown;

  modport master (
    output load, value, blink_en,
    input  seg, shown
  );

  modport slave (
    input  load, value, blink_en,
    output seg, shown
  );
endinterface

// File: rtl/hex_display_n.sv
// N-digit active-low 7-segment hex display with latched value and optional blink.
// Leading-zero blanking is compiled in when HEX_DISPLAY_LZ_BLANK_EN is defined.
module hex_display_n #(
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  hex_display_n_if.slave bus
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {ON = 1'b0, OFF = 1'b1} phase_t;

  function automatic logic [6:0] enc_nibble(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      default: c = 7'h0E;
    endcase
    return c;
  endfunction

  // Full display word for a latched value; blank forces every digit dark.
  function automatic logic [7*DIGITS-1:0] seg_encode(input logic [4*DIGITS-1:0] v,
                                                     input logic blank);
    logic [7*DIGITS-1:0] s;
    logic                zero_above;
    s = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (v[4*k +: 4] == 4'h0);
      s[7*k +: 7] = enc_nibble(v[4*k +: 4]);
`ifdef HEX_DISPLAY_LZ_BLANK_EN
      if ((k > 0) && zero_above)
        s[7*k +: 7] = SEG_BLANK;
`endif
      if (blank)
        s[7*k +: 7] = SEG_BLANK;
    end
    return s;
  endfunction

  logic [4*DIGITS-1:0] shown_p0;
  logic [CNT_W-1:0]    cnt_p0;
  phase_t              phase_p0;
  logic [7*DIGITS-1:0] seg_p1;

  // Stage 0: value latch, blink counter and phase state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      shown_p0 <= '0;
      cnt_p0   <= '0;
      phase_p0 <= ON;
    end else begin
      if (bus.load)
        shown_p0 <= bus.value;
      if (!bus.blink_en) begin
        cnt_p0   <= '0;
        phase_p0 <= ON;
      end else if (cnt_p0 == CNT_TERM) begin
        cnt_p0 <= '0;
        case (phase_p0)
          ON:      phase_p0 <= OFF;
          default: phase_p0 <= ON;
        endcase
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage 1: registered segment drive from the stage-0 state
  always_ff @(posedge clk) begin
    if (rst)
      seg_p1 <= seg_encode('0, 1'b0);
    else
      seg_p1 <= seg_encode(shown_p0, phase_p0 == OFF);
  end

  assign bus.shown = shown_p0;
  assign bus.seg   = seg_p1;

endmodule

// File: tb/tb_hex_display_n.sv
// Self-checking bench for hex_display_n (DIGITS=2, BLINK_DIV=4): directed steps then random traffic.
module tb_hex_display_n;

  localparam int ND   = 2;
  localparam int BDIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hex_display_n_if #(.DIGITS(ND)) bus ();

  hex_display_n #(.DIGITS(ND), .BLINK_DIV(BDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: latched value, edges spent with blink enabled, derived phase.
  int          sh_m;
  int          n_m;
  bit          ph_m;
  logic [13:0] seg_m;

  function automatic logic [13:0] seg_model(input int v, input bit blank);
    logic [13:0] s;
    for (int k = 0; k < ND; k++) begin
      int nib;
      nib = (v >> (4 * k)) & 15;
      s[7*k +: 7] = tbl[nib];
`ifdef HEX_DISPLAY_LZ_BLANK_EN
      if (k > 0 && (v >> (4 * k)) == 0) s[7*k +: 7] = 7'h7F;
`endif
      if (blank) s[7*k +: 7] = 7'h7F;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [7:0] v, input logic be);
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.blink_en = be;
    @(posedge clk);
    if (r) begin
      sh_m  = 0;
      n_m   = 0;
      seg_m = seg_model(0, 1'b0);
    end else begin
      seg_m = seg_model(sh_m, ph_m);
      if (ld) sh_m = int'(v);
      if (be) n_m++;
      else    n_m = 0;
    end
    ph_m = ((n_m / BDIV) % 2) == 1;
    #1;
    chk("shown", 32'(bus.shown), 32'(sh_m));
    chk("seg",   32'(bus.seg),   32'(seg_m));
  endtask

  initial begin
    bit be_r;
    sh_m = 0; n_m = 0; ph_m = 1'b0; seg_m = '0;
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.blink_en = 1'b0;

    // Reset, with load and blink asserted to confirm reset priority
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_shown", 32'(bus.shown), 32'h0);
`ifdef HEX_DISPLAY_LZ_BLANK_EN
    chk("rst_seg", 32'(bus.seg), 32'({7'h7F, 7'h40}));
`else
    chk("rst_seg", 32'(bus.seg), 32'({7'h40, 7'h40}));
`endif
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Load 3A: shown after one edge, seg after two; value change without load is ignored
    step(1'b0, 1'b1, 8'h3A, 1'b0);
    chk("load_shown", 32'(bus.shown), 32'h3A);
    step(1'b0, 1'b0, 8'h77, 1'b0);
    chk("load_seg", 32'(bus.seg), 32'({7'h30, 7'h08}));
    step(1'b0, 1'b0, 8'h12, 1'b0);
    chk("hold_seg", 32'(bus.seg), 32'({7'h30, 7'h08}));

    // Encoding sweep 00,11,..,FF
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i * 17), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Blink with 5A loaded, disabled part-way through the blank phase
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("blink_pre", 32'(bus.seg), 32'({7'h12, 7'h08}));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("blink_off", 32'(bus.seg), 32'h3FFF);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("blink_dis", 32'(bus.seg), 32'({7'h12, 7'h08}));

    // Full blink cycle from a cleared counter
    for (int i = 0; i < 2 * BDIV + 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Load 0F on the terminal-count edge
    for (int i = 0; i < BDIV - 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 1'b1);
    chk("coll_shown", 32'(bus.shown), 32'h0F);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("coll_seg", 32'(bus.seg), 32'h3FFF);
    // Load during blank shows up at the next shown phase
    step(1'b0, 1'b1, 8'hC4, 1'b1);
    for (int i = 0; i < BDIV; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("blank_load", 32'(bus.seg), 32'({7'h46, 7'h19}));

    // Reset mid-blink restarts the half-period
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < BDIV + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Leading-zero cases
    step(1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef HEX_DISPLAY_LZ_BLANK_EN
    chk("lz_05", 32'(bus.seg), 32'({7'h7F, 7'h12}));
`else
    chk("lz_05", 32'(bus.seg), 32'({7'h40, 7'h12}));
`endif
    step(1'b0, 1'b1, 8'h50, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lz_50", 32'(bus.seg), 32'({7'h12, 7'h40}));
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic
    be_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) be_r = ~be_r;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), be_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
